// File: rtl/boreal_cardiac_pkg.sv
// Shared types and default timing constants for the cardiac-gated tVNS inhibit logic.
// Intervals are counted in 1 ms ticks held in 12-bit counters.
package boreal_cardiac_pkg;

   typedef enum logic [1:0] {
      ST_ACQUIRE = 2'd0,
      ST_ARMED   = 2'd1,
      ST_LOCKED  = 2'd2
   } state_e;

   localparam int DEFAULT_TICK_CYCLES = 100_000;
   localparam int DEFAULT_REFRACT_MS  = 250;
   localparam int DEFAULT_RR_MIN_MS   = 300;
   localparam int DEFAULT_RR_MAX_MS   = 2000;

   localparam int MS_W = 12;

   // Exponential RR average: (3*avg + rr) / 4, with a 14-bit intermediate so nothing overflows.
   function automatic logic [MS_W-1:0] rr_blend(input logic [MS_W-1:0] avg,
                                                input logic [MS_W-1:0] rr);
      logic [MS_W+1:0] sum;
      sum = (14'd3 * {2'b00, avg}) + {2'b00, rr};
      return sum[MS_W+1:2];
   endfunction

endpackage

// File: rtl/boreal_cardiac_gate_ms_tick.sv
// Millisecond prescaler: one-cycle tick every TICK_CYCLES clocks, restartable by clear.
// The module name is boreal_ms_tick; a clear suppresses the tick of that cycle.
module boreal_ms_tick
   import boreal_cardiac_pkg::*;
#(
   parameter int TICK_CYCLES = DEFAULT_TICK_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int CW = $clog2(TICK_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          wrap;

   assign wrap = (cnt_q == LAST);
   assign tick = wrap && !clear;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clear || wrap) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/boreal_cardiac_gate.sv
// Cardiac gate: tracks R-R intervals, locks onto a stable rhythm and forbids tVNS
// stimulation except outside the T-wave window [avg/8, avg/2) after each beat.
module boreal_cardiac_gate
   import boreal_cardiac_pkg::*;
#(
   parameter int TICK_CYCLES = DEFAULT_TICK_CYCLES,
   parameter int REFRACT_MS  = DEFAULT_REFRACT_MS,
   parameter int RR_MIN_MS   = DEFAULT_RR_MIN_MS,
   parameter int RR_MAX_MS   = DEFAULT_RR_MAX_MS
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            r_peak,
   output logic            t_wave_inhibit,
   output logic            locked,
   output logic [MS_W-1:0] rr_ms,
   output logic            rr_valid
);

   localparam logic [MS_W-1:0] REFRACT    = MS_W'(REFRACT_MS);
   localparam logic [MS_W-1:0] RR_MIN     = MS_W'(RR_MIN_MS);
   localparam logic [MS_W-1:0] RR_MAX     = MS_W'(RR_MAX_MS);
   localparam logic [MS_W-1:0] TIMEOUT_MS = MS_W'(RR_MAX_MS + 1);
   localparam logic [MS_W-1:0] MS_SAT     = '1;

   state_e          state_q, state_d;
   logic [MS_W-1:0] ms_q, ms_d;
   logic [MS_W-1:0] avg_q, avg_d;
   logic [MS_W-1:0] win_start_q, win_start_d;
   logic [MS_W-1:0] win_end_q, win_end_d;
   logic [MS_W-1:0] rr_ms_q, rr_ms_d;
   logic            rr_valid_q, rr_valid_d;
   logic            locked_q, locked_d;
   logic            inhibit_q, inhibit_d;

   logic tick;
   logic refractory;
   logic accept;
   logic in_range;
   logic rr_good;
   logic timeout;

   boreal_ms_tick #(
      .TICK_CYCLES (TICK_CYCLES)
   ) u_ms_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (accept),
      .tick  (tick)
   );

   // In ACQUIRE there is no reference beat yet, so every peak is taken.
   assign refractory = (state_q != ST_ACQUIRE) && (ms_q < REFRACT);
   assign accept     = r_peak && !refractory;
   assign in_range   = (ms_q >= RR_MIN) && (ms_q <= RR_MAX);
   assign rr_good    = accept && (state_q != ST_ACQUIRE) && in_range;
   assign timeout    = (state_q != ST_ACQUIRE) && (ms_q >= TIMEOUT_MS);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_ACQUIRE;
         ms_q        <= '0;
         avg_q       <= '0;
         win_start_q <= '0;
         win_end_q   <= '0;
         rr_ms_q     <= '0;
         rr_valid_q  <= 1'b0;
         locked_q    <= 1'b0;
         inhibit_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         ms_q        <= ms_d;
         avg_q       <= avg_d;
         win_start_q <= win_start_d;
         win_end_q   <= win_end_d;
         rr_ms_q     <= rr_ms_d;
         rr_valid_q  <= rr_valid_d;
         locked_q    <= locked_d;
         inhibit_q   <= inhibit_d;
      end
   end

   // An accepted peak always takes priority over the loss-of-beat timeout.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_ACQUIRE: begin
            if (accept) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (accept)       state_d = in_range ? ST_LOCKED : ST_ARMED;
            else if (timeout) state_d = ST_ACQUIRE;
         end
         ST_LOCKED: begin
            if (accept)       state_d = in_range ? ST_LOCKED : ST_ARMED;
            else if (timeout) state_d = ST_ACQUIRE;
         end
         default: state_d = ST_ACQUIRE;
      endcase
   end

   always_comb begin
      ms_d        = ms_q;
      avg_d       = avg_q;
      win_start_d = win_start_q;
      win_end_d   = win_end_q;
      rr_ms_d     = rr_ms_q;
      rr_valid_d  = rr_good;

      if (accept) begin
         ms_d = '0;
      end else if (tick && (ms_q != MS_SAT)) begin
         ms_d = ms_q + MS_W'(1);
      end

      if (rr_good) begin
         avg_d   = (state_q == ST_LOCKED) ? rr_blend(avg_q, ms_q) : ms_q;
         rr_ms_d = ms_q;
      end

      if (accept) begin
         win_start_d = avg_d >> 3;
         win_end_d   = avg_d >> 1;
      end

      locked_d  = (state_d == ST_LOCKED);
      inhibit_d = (state_q != ST_LOCKED) ||
                  ((ms_q >= win_start_q) && (ms_q < win_end_q));
   end

   assign t_wave_inhibit = inhibit_q;
   assign locked         = locked_q;
   assign rr_ms          = rr_ms_q;
   assign rr_valid       = rr_valid_q;

endmodule

// File: tb/tb_boreal_cardiac_gate.sv
// Directed bench for boreal_cardiac_gate with a 10-cycle ms tick; rr_ms updates are
// scoreboarded, inhibit/locked are checked at chosen ms offsets after each accepted R.
module tb_boreal_cardiac_gate;

   localparam int TICK = 10;

   logic        clk;
   logic        rst;
   logic        r_peak;
   logic        t_wave_inhibit;
   logic        locked;
   logic [11:0] rr_ms;
   logic        rr_valid;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int ref_cyc = 0;
   int exp_q[$];

   boreal_cardiac_gate #(
      .TICK_CYCLES (TICK)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .r_peak         (r_peak),
      .t_wave_inhibit (t_wave_inhibit),
      .locked         (locked),
      .rr_ms          (rr_ms),
      .rr_valid       (rr_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Every rr_valid pulse must match the oldest queued interval.
   always @(negedge clk) begin : monitor
      int e;
      if (rst === 1'b0 && rr_valid === 1'b1) begin
         chk("rr_valid_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rr_ms_scoreboard", 32'(rr_ms), 32'(e));
         end
      end
   end

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic pulse_peak();
      r_peak = 1'b1;
      @(negedge clk);
      r_peak = 1'b0;
   endtask

   // Peak sampled at ref+10*ms+5, i.e. while ms_since_r == ms.
   task automatic peak_at(input int ms);
      wait_until(ref_cyc + TICK * ms + 4);
      pulse_peak();
   endtask

   task automatic at_ms(input int ms);
      wait_until(ref_cyc + TICK * ms + 6);
   endtask

   task automatic check_inh(input int ms, input logic expv);
      at_ms(ms);
      chk($sformatf("inhibit_at_%0dms", ms), 32'(t_wave_inhibit), 32'(expv));
   endtask

   initial begin
      rst    = 1'b1;
      r_peak = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_inhibit", 32'(t_wave_inhibit), 32'd1);
      chk("reset_locked", 32'(locked), 32'd0);
      chk("reset_rr_valid", 32'(rr_valid), 32'd0);
      chk("reset_rr_ms", 32'(rr_ms), 32'd0);
      rst = 1'b0;

      repeat (3000 * TICK) @(negedge clk);
      chk("idle_inhibit", 32'(t_wave_inhibit), 32'd1);
      chk("idle_locked", 32'(locked), 32'd0);

      pulse_peak();
      ref_cyc = cyc;
      chk("first_peak_locked", 32'(locked), 32'd0);
      chk("first_peak_rr_valid", 32'(rr_valid), 32'd0);

      exp_q.push_back(1000);
      peak_at(1000);
      ref_cyc = cyc;
      chk("lock_rr_valid", 32'(rr_valid), 32'd1);
      chk("lock_rr_ms", 32'(rr_ms), 32'd1000);
      chk("lock_locked", 32'(locked), 32'd1);
      @(negedge clk);
      chk("lock_rr_valid_one_cycle", 32'(rr_valid), 32'd0);
      check_inh(124, 1'b0);
      check_inh(125, 1'b1);
      check_inh(499, 1'b1);
      check_inh(500, 1'b0);

      exp_q.push_back(800);
      peak_at(800);
      ref_cyc = cyc;
      check_inh(117, 1'b0);
      check_inh(118, 1'b1);

      exp_q.push_back(800);
      peak_at(800);
      ref_cyc = cyc;
      check_inh(113, 1'b0);
      check_inh(114, 1'b1);
      check_inh(455, 1'b1);
      check_inh(456, 1'b0);

      at_ms(460);
      chk("pre_reset_locked", 32'(locked), 32'd1);
      chk("pre_reset_inhibit", 32'(t_wave_inhibit), 32'd0);
      #1 rst = 1'b1;
      #1;
      chk("async_reset_inhibit", 32'(t_wave_inhibit), 32'd1);
      chk("async_reset_locked", 32'(locked), 32'd0);
      chk("async_reset_rr_ms", 32'(rr_ms), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      pulse_peak();
      ref_cyc = cyc;
      chk("relock_first_locked", 32'(locked), 32'd0);
      chk("relock_first_rr_valid", 32'(rr_valid), 32'd0);

      exp_q.push_back(300);
      peak_at(300);
      ref_cyc = cyc;
      chk("relock_second_locked", 32'(locked), 32'd1);
      chk("relock_second_rr_valid", 32'(rr_valid), 32'd1);
      check_inh(36, 1'b0);
      check_inh(37, 1'b1);

      peak_at(100);
      chk("refractory_rr_valid", 32'(rr_valid), 32'd0);
      chk("refractory_locked", 32'(locked), 32'd1);
      check_inh(149, 1'b1);
      check_inh(150, 1'b0);

      peak_at(280);
      ref_cyc = cyc;
      chk("short_rr_locked", 32'(locked), 32'd0);
      chk("short_rr_rr_valid", 32'(rr_valid), 32'd0);
      check_inh(200, 1'b1);

      exp_q.push_back(300);
      peak_at(300);
      ref_cyc = cyc;
      chk("rearm_locked", 32'(locked), 32'd1);
      chk("rearm_rr_ms", 32'(rr_ms), 32'd300);

      at_ms(2000);
      chk("before_timeout_locked", 32'(locked), 32'd1);
      chk("before_timeout_inhibit", 32'(t_wave_inhibit), 32'd0);
      at_ms(2001);
      chk("timeout_locked", 32'(locked), 32'd0);
      chk("timeout_inhibit", 32'(t_wave_inhibit), 32'd1);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/boreal_cardiac_gate.md
BOREAL_CARDIAC_GATE -- requirements
Module: boreal_cardiac_gate

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  TICK_CYCLES, 100_000, clk cycles per 1 ms tick at 100 MHz.
  REFRACT_MS, 250, R-peaks closer than this to the last accepted R are ignored.
  RR_MIN_MS, 300, shortest valid RR interval (200 bpm).
  RR_MAX_MS, 2000, longest valid RR interval (30 bpm); also the loss-of-beat timeout.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  100 MHz system clock.
  rst  in  1  reset, asynchronous, active-high.
  r_peak  in  1  single-cycle R-peak strobe from the ECG detector, synchronous to clk.
  t_wave_inhibit  out  1  to the tVNS stimulator; 1 = stimulation forbidden.
  locked  out  1  1 only in state LOCKED.
  rr_ms  out  12  last valid RR interval, in ms.
  rr_valid  out  1  one-cycle strobe when rr_ms updates.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.

Function
REQ-004 The prescaler SHALL emit a 1-cycle tick every TICK_CYCLES cycles; an accepted R-peak SHALL clear it to 0.
REQ-005 ms_since_r (12 bit) SHALL increment on each tick, saturate at 4095, and clear to 0 on an accepted R-peak.
REQ-006 The states SHALL be ACQUIRE, ARMED and LOCKED.
REQ-007 In ARMED and LOCKED, an r_peak with ms_since_r < REFRACT_MS SHALL be ignored, with no state, counter or output change.
REQ-008 Any other r_peak SHALL be accepted; interval = ms_since_r; valid iff RR_MIN_MS <= interval <= RR_MAX_MS.
REQ-009 ACQUIRE: an r_peak (no refractory check) SHALL be accepted and the state SHALL go to ARMED.
REQ-010 ARMED: a valid interval SHALL go to LOCKED and seed rr_avg = interval; an invalid interval SHALL stay in ARMED with a new reference.
REQ-011 LOCKED: a valid interval SHALL stay in LOCKED and set rr_avg = (3*rr_avg + interval) >> 2 (14-bit intermediate, truncated); an invalid interval SHALL go to ARMED.
REQ-012 In ARMED and LOCKED, ms_since_r reaching RR_MAX_MS + 1 without an accepted r_peak SHALL go to ACQUIRE.
REQ-013 If a timeout and an accepted r_peak fall in the same cycle, the r_peak SHALL win.
REQ-014 On every accepted R-peak, win_start = new rr_avg >> 3 and win_end = new rr_avg >> 1 SHALL be latched.
REQ-015 t_wave_inhibit SHALL be registered with 1-cycle latency.
  - Value = (state != LOCKED) OR (win_start <= ms_since_r < win_end).
  - The value uses the state and counters of the previous cycle.
REQ-016 Each valid interval SHALL update rr_ms and pulse rr_valid for 1 cycle, aligned with the state update.
REQ-017 locked SHALL be registered and equal (state == LOCKED).

Reset
REQ-018 Reset SHALL force the following, and no output SHALL glitch low during reset:
  - state = ACQUIRE, t_wave_inhibit = 1, locked = 0;
  - rr_ms, rr_avg, rr_valid, ms_since_r, prescaler and windows = 0.
REQ-019 Reset asserted mid-beat SHALL discard the lock; after release, two accepted R-peaks SHALL be needed to re-lock.

Structure
REQ-020 A shared package boreal_cardiac_pkg SHALL hold the state encoding (2 bit) and the default constants TICK_CYCLES, REFRACT_MS, RR_MIN_MS and RR_MAX_MS.
REQ-021 The prescaler SHALL be a sub-module boreal_ms_tick (ports: clk, rst, clear, tick).
REQ-022 All other logic (FSM, averaging, window compare) SHALL be in boreal_cardiac_gate, with no combinational path from input to output.

Verification (bench overrides TICK_CYCLES = 10)
REQ-023 Reset, then idle 3000 ms -> t_wave_inhibit = 1, locked = 0, rr_valid never pulses.
REQ-024 R-peaks every 1000 ms:
  - the 2nd peak gives locked = 1 and rr_ms = 1000 with a 1-cycle rr_valid;
  - afterwards, inhibit = 1 exactly for ms 125..499 after each R and 0 elsewhere.
REQ-025 Locked at 1000 ms, then peaks at 800 ms -> rr_avg = 950, then 912; the window moves to 114..455 ms.
REQ-026 Locked, then an extra r_peak 100 ms after R -> ignored: no rr_valid and an unchanged window.
  - An r_peak at 280 ms instead -> ARMED, locked = 0 and inhibit = 1.
REQ-027 Locked, then no r_peak for 2001 ms -> ACQUIRE and inhibit = 1.
  - Rst pulsed mid-window -> inhibit = 1 immediately, and re-lock needs two peaks.
